// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the dcache port arbiter: memory sizes, store-queue packets,
// the dcache request packet and the arbiter FSM states. The packet structs are
// sized for the default system widths (XLEN 32, 8-entry SQ, 6-bit tags).
package dcache_port_arbiter_pkg;

  localparam int SYS_XLEN  = 32;
  localparam int SYS_N_SQ  = 8;
  localparam int SYS_POS_W = $clog2(SYS_N_SQ) + 1;
  localparam int SYS_TAG_W = 6;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } MEM_SIZE;

  typedef struct packed {
    logic [SYS_XLEN-1:0]  addr;
    logic [SYS_XLEN-1:0]  data;
    MEM_SIZE              size;
    logic [SYS_POS_W-1:0] store_pos;
  } STORE_PACKET_RET;

  typedef struct packed {
    logic                 valid;
    logic [SYS_POS_W-1:0] store_pos;
  } STORE_PACKET_EX_STAGE;

  typedef struct packed {
    logic                 wr;
    logic [SYS_XLEN-1:0]  addr;
    logic [SYS_XLEN-1:0]  data;
    MEM_SIZE              size;
    logic [SYS_TAG_W-1:0] tag;
  } DCACHE_REQ_PACKET;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2
  } ARB_STATE;

  // Saturating increment for the 32-bit performance counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_store_commit_fifo.sv
// Commit buffer for retired stores: up to N_WAY pushes per cycle packed in lane
// order, one pop per cycle from the head. push_ok says there is room for a full
// retire group; pushes offered while it is low are dropped.
module store_commit_fifo #(
  parameter int N_WAY = 2,
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_WAY-1:0]         push_valid,
  input  logic [N_WAY*W-1:0]       push_data,
  input  logic                     pop,
  output logic                     push_ok,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [N_WAY-1:0] wr_en_s;
  logic [PW-1:0]    wr_idx_s [N_WAY];
  logic [CW-1:0]    npush_s;

  assign push_ok   = (count_r <= CW'(DEPTH - N_WAY));
  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Compact valid lanes onto consecutive slots starting at the write pointer.
  always_comb begin
    npush_s = '0;
    wr_en_s = '0;
    for (int i = 0; i < N_WAY; i++) begin
      wr_idx_s[i] = wr_ptr_r + npush_s[PW-1:0];
      if (push_ok && push_valid[i]) begin
        wr_en_s[i] = 1'b1;
        npush_s    = npush_s + CW'(1);
      end else begin
        wr_en_s[i] = 1'b0;
      end
    end
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + npush_s[PW-1:0];
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r + npush_s - {{(CW-1){1'b0}}, pop};
    end
  end

  // Entry storage; contents are don't-care once the count says empty.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_WAY; i++) begin
      if (wr_en_s[i]) begin
        mem_r[wr_idx_s[i]] <= push_data[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single dcache request port between load lookups and retired
// stores. Stores wait in a commit buffer; a 3-state FSM issues one request at a
// time and holds each store write until the dcache reports completion, then
// returns its store_pos to the store queue.
// Optional: define DCACHE_ARB_PERF_EN to add saturating performance counters.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int N_WAY        = 2,
  parameter int N_SQ         = 8,
  parameter int XLEN         = 32,
  parameter int TAG_W        = 6,
  parameter int CBUF_DEPTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_WAY-1:0]                    st_ret_valid,
  input  logic [N_WAY*XLEN-1:0]               st_ret_addr,
  input  logic [N_WAY*XLEN-1:0]               st_ret_data,
  input  logic [N_WAY*2-1:0]                  st_ret_size,
  input  logic [N_WAY*($clog2(N_SQ)+1)-1:0]   st_ret_pos,
  output logic                                st_ret_ready,
  input  logic                                branch_haz,
  input  logic [N_WAY-1:0]                    ld_req_valid,
  input  logic [N_WAY*XLEN-1:0]               ld_req_addr,
  input  logic [N_WAY*2-1:0]                  ld_req_size,
  input  logic [N_WAY*TAG_W-1:0]              ld_req_tag,
  output logic [N_WAY-1:0]                    ld_req_ready,
  output logic                                dc_req_valid,
  output logic                                dc_req_wr,
  output logic [XLEN-1:0]                     dc_req_addr,
  output logic [XLEN-1:0]                     dc_req_data,
  output logic [1:0]                          dc_req_size,
  output logic [TAG_W-1:0]                    dc_req_tag,
  input  logic                                dc_req_ready,
  input  logic                                dc_wr_done,
  output logic                                sq_done_valid,
  output logic [$clog2(N_SQ):0]               sq_done_pos,
  output logic [$clog2(CBUF_DEPTH):0]         cbuf_count
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [31:0]                         perf_ld_grants,
  output logic [31:0]                         perf_st_grants,
  output logic [31:0]                         perf_starve_forces,
  output logic [31:0]                         perf_full_stalls
`endif
);

  localparam int POS_W = $clog2(N_SQ) + 1;
  localparam int CNT_W = $clog2(CBUF_DEPTH) + 1;
  localparam int ENT_W = 2 * XLEN + 2 + POS_W;
  localparam int IW    = (N_WAY > 1) ? $clog2(N_WAY) : 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  ARB_STATE               state_r;
  ARB_STATE               state_nxt_s;
  logic [N_WAY*ENT_W-1:0] push_data_s;
  logic [ENT_W-1:0]       head_s;
  logic                   cap_st_s;
  logic                   cap_ld_s;
  logic                   ld_hit_s;
  logic [IW-1:0]          ld_idx_s;
  logic [SC_W-1:0]        starve_r;
  logic                   starved_s;
  logic                   cbuf_full_s;
  logic                   cbuf_nonempty_s;
  logic [POS_W-1:0]       pos_r;

  assign cbuf_full_s     = (cbuf_count == CNT_W'(CBUF_DEPTH));
  assign cbuf_nonempty_s = (cbuf_count != '0);
  assign starved_s       = (starve_r >= SC_W'(STARVE_LIMIT));

  // Pack each retire lane as {addr, data, size, pos} for the commit buffer.
  always_comb begin
    push_data_s = '0;
    for (int i = 0; i < N_WAY; i++) begin
      push_data_s[i*ENT_W +: ENT_W] = {st_ret_addr[i*XLEN +: XLEN], st_ret_data[i*XLEN +: XLEN],
                                       st_ret_size[i*2 +: 2], st_ret_pos[i*POS_W +: POS_W]};
    end
  end

  store_commit_fifo #(
    .N_WAY (N_WAY),
    .DEPTH (CBUF_DEPTH),
    .W     (ENT_W)
  ) u_cbuf (
    .clock      (clock),
    .reset      (reset),
    .push_valid (st_ret_valid),
    .push_data  (push_data_s),
    .pop        (cap_st_s),
    .push_ok    (st_ret_ready),
    .head_data  (head_s),
    .count      (cbuf_count)
  );

  // Lowest-index valid load lane.
  always_comb begin
    ld_hit_s = 1'b0;
    ld_idx_s = '0;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (ld_req_valid[i]) begin
        ld_hit_s = 1'b1;
        ld_idx_s = IW'(i);
      end else begin
        ld_hit_s = ld_hit_s;
      end
    end
  end

  // Next state and winner selection; only IDLE captures a new request.
  always_comb begin
    state_nxt_s = state_r;
    cap_st_s    = 1'b0;
    cap_ld_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (reset) begin
          state_nxt_s = IDLE;
        end else if (cbuf_nonempty_s && (cbuf_full_s || starved_s)) begin
          cap_st_s    = 1'b1;
          state_nxt_s = ISSUE;
        end else if (ld_hit_s && !branch_haz) begin
          cap_ld_s    = 1'b1;
          state_nxt_s = ISSUE;
        end else if (cbuf_nonempty_s) begin
          cap_st_s    = 1'b1;
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (dc_req_ready) begin
          state_nxt_s = dc_req_wr ? WAIT_ACK : IDLE;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT_ACK: begin
        if (dc_wr_done) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_ACK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Grant pulse back to the captured load lane.
  always_comb begin
    ld_req_ready = '0;
    if (cap_ld_s) begin
      ld_req_ready[ld_idx_s] = 1'b1;
    end else begin
      ld_req_ready = '0;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request register: loaded on capture, held while stalled, dropped on accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      dc_req_valid <= 1'b0;
      dc_req_wr    <= 1'b0;
      dc_req_addr  <= '0;
      dc_req_data  <= '0;
      dc_req_size  <= 2'd0;
      dc_req_tag   <= '0;
      pos_r        <= '0;
    end else if (cap_st_s) begin
      dc_req_valid <= 1'b1;
      dc_req_wr    <= 1'b1;
      dc_req_addr  <= head_s[ENT_W-1 -: XLEN];
      dc_req_data  <= head_s[ENT_W-XLEN-1 -: XLEN];
      dc_req_size  <= head_s[POS_W+1 -: 2];
      dc_req_tag   <= '0;
      pos_r        <= head_s[POS_W-1:0];
    end else if (cap_ld_s) begin
      dc_req_valid <= 1'b1;
      dc_req_wr    <= 1'b0;
      dc_req_addr  <= ld_req_addr[ld_idx_s*XLEN +: XLEN];
      dc_req_data  <= '0;
      dc_req_size  <= ld_req_size[ld_idx_s*2 +: 2];
      dc_req_tag   <= ld_req_tag[ld_idx_s*TAG_W +: TAG_W];
    end else if ((state_r == ISSUE) && dc_req_ready) begin
      dc_req_valid <= 1'b0;
    end else begin
      dc_req_valid <= dc_req_valid;
    end
  end

  // One-cycle completion pulse carrying the held store position.
  always_ff @(posedge clock) begin
    if (reset) begin
      sq_done_valid <= 1'b0;
      sq_done_pos   <= '0;
    end else if ((state_r == WAIT_ACK) && dc_wr_done) begin
      sq_done_valid <= 1'b1;
      sq_done_pos   <= pos_r;
    end else begin
      sq_done_valid <= 1'b0;
    end
  end

  // Consecutive load wins while stores wait; a store capture clears it.
  always_ff @(posedge clock) begin
    if (reset || cap_st_s) begin
      starve_r <= '0;
    end else if (cap_ld_s && cbuf_nonempty_s && !starved_s) begin
      starve_r <= starve_r + SC_W'(1);
    end else begin
      starve_r <= starve_r;
    end
  end

`ifdef DCACHE_ARB_PERF_EN
  // Saturating grant, starvation-force and full-buffer stall counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_ld_grants     <= 32'd0;
      perf_st_grants     <= 32'd0;
      perf_starve_forces <= 32'd0;
      perf_full_stalls   <= 32'd0;
    end else begin
      perf_ld_grants     <= cap_ld_s ? sat_inc32(perf_ld_grants) : perf_ld_grants;
      perf_st_grants     <= cap_st_s ? sat_inc32(perf_st_grants) : perf_st_grants;
      perf_starve_forces <= (cap_st_s && starved_s) ? sat_inc32(perf_starve_forces) : perf_starve_forces;
      perf_full_stalls   <= !st_ret_ready ? sat_inc32(perf_full_stalls) : perf_full_stalls;
    end
  end
`endif

  dcache_port_arbiter_chk #(.N_WAY(N_WAY)) u_chk (
    .clock        (clock),
    .reset        (reset),
    .st_ret_valid (st_ret_valid),
    .st_ret_ready (st_ret_ready)
  );

endmodule

// Protocol checker: retired stores must not be offered while the buffer is not ready.
module dcache_port_arbiter_chk #(
  parameter int N_WAY = 2
) (
  input logic             clock,
  input logic             reset,
  input logic [N_WAY-1:0] st_ret_valid,
  input logic             st_ret_ready
);

  a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
    !((|st_ret_valid) && !st_ret_ready));

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Randomised bench for dcache_port_arbiter with a queue-based reference model
// and a decoupled monitor that checks dcache requests and SQ completions.
module tb_dcache_port_arbiter;

  localparam int N_WAY = 2;
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int DEPTH = 4;
  localparam int LIMIT = 4;
  localparam int POS_W = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [3:0]  pos;
  } st_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [5:0]  tag;
  } req_t;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [N_WAY-1:0]          st_ret_valid;
  logic [N_WAY*XLEN-1:0]     st_ret_addr;
  logic [N_WAY*XLEN-1:0]     st_ret_data;
  logic [N_WAY*2-1:0]        st_ret_size;
  logic [N_WAY*POS_W-1:0]    st_ret_pos;
  logic                      st_ret_ready;
  logic                      branch_haz;
  logic [N_WAY-1:0]          ld_req_valid;
  logic [N_WAY*XLEN-1:0]     ld_req_addr;
  logic [N_WAY*2-1:0]        ld_req_size;
  logic [N_WAY*TAG_W-1:0]    ld_req_tag;
  logic [N_WAY-1:0]          ld_req_ready;
  logic                      dc_req_valid;
  logic                      dc_req_wr;
  logic [XLEN-1:0]           dc_req_addr;
  logic [XLEN-1:0]           dc_req_data;
  logic [1:0]                dc_req_size;
  logic [TAG_W-1:0]          dc_req_tag;
  logic                      dc_req_ready;
  logic                      dc_wr_done;
  logic                      sq_done_valid;
  logic [POS_W-1:0]          sq_done_pos;
  logic [2:0]                cbuf_count;
`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] perf_ld_grants, perf_st_grants, perf_starve_forces, perf_full_stalls;
`endif

  always #5 clock = ~clock;

  dcache_port_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .st_ret_valid  (st_ret_valid),
    .st_ret_addr   (st_ret_addr),
    .st_ret_data   (st_ret_data),
    .st_ret_size   (st_ret_size),
    .st_ret_pos    (st_ret_pos),
    .st_ret_ready  (st_ret_ready),
    .branch_haz    (branch_haz),
    .ld_req_valid  (ld_req_valid),
    .ld_req_addr   (ld_req_addr),
    .ld_req_size   (ld_req_size),
    .ld_req_tag    (ld_req_tag),
    .ld_req_ready  (ld_req_ready),
    .dc_req_valid  (dc_req_valid),
    .dc_req_wr     (dc_req_wr),
    .dc_req_addr   (dc_req_addr),
    .dc_req_data   (dc_req_data),
    .dc_req_size   (dc_req_size),
    .dc_req_tag    (dc_req_tag),
    .dc_req_ready  (dc_req_ready),
    .dc_wr_done    (dc_wr_done),
    .sq_done_valid (sq_done_valid),
    .sq_done_pos   (sq_done_pos),
    .cbuf_count    (cbuf_count)
`ifdef DCACHE_ARB_PERF_EN
    ,
    .perf_ld_grants     (perf_ld_grants),
    .perf_st_grants     (perf_st_grants),
    .perf_starve_forces (perf_starve_forces),
    .perf_full_stalls   (perf_full_stalls)
`endif
  );

  // Reference model state
  st_t         cbuf_q[$];
  req_t        exp_req_q[$];
  logic [3:0]  exp_done_q[$];
  int          phase_m;      // 0 idle, 1 request outstanding, 2 waiting for write done
  bit          cur_wr_m;
  logic [3:0]  cur_pos_m;
  int          starve_m;
  bit          ld_pend[N_WAY];
  logic [31:0] ld_addr_m[N_WAY];
  logic [1:0]  ld_size_m[N_WAY];
  logic [5:0]  ld_tag_m[N_WAY];
  logic [3:0]  pos_ctr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare presented requests and completions with the scoreboard.
  always @(negedge clock) begin
    req_t r;
    #2;
    if (dc_req_valid) begin
      if (exp_req_q.size() == 0) begin
        chk("req_unexpected", 64'd1, 64'd0);
      end else begin
        r = exp_req_q[0];
        chk("req_wr", dc_req_wr, r.wr);
        chk("req_addr", dc_req_addr, r.addr);
        chk("req_data", dc_req_data, r.data);
        chk("req_size", dc_req_size, r.size);
        chk("req_tag", dc_req_tag, r.tag);
        if (dc_req_ready) void'(exp_req_q.pop_front());
      end
    end
    if (sq_done_valid) begin
      if (exp_done_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
      else chk("done_pos", sq_done_pos, exp_done_q.pop_front());
    end
  end

  // Apply the arbitration rules for the cycle ending at the next rising edge.
  task automatic model_eval();
    logic [N_WAY-1:0] exp_ldr;
    int pre_size;
    int li;
    st_t s;
    req_t r;
    exp_ldr  = '0;
    pre_size = cbuf_q.size();
    li       = -1;
    if (reset) begin
      cbuf_q.delete();
      exp_req_q.delete();
      exp_done_q.delete();
      phase_m  = 0;
      starve_m = 0;
      for (int i = 0; i < N_WAY; i++) ld_pend[i] = 1'b0;
      return;
    end
    chk("st_ret_ready", st_ret_ready, pre_size <= DEPTH - N_WAY);
    chk("cbuf_count", cbuf_count, pre_size);
    chk("dc_req_valid", dc_req_valid, phase_m == 1);
    if (phase_m == 0) begin
      for (int i = N_WAY - 1; i >= 0; i--) if (ld_pend[i]) li = i;
      if (pre_size > 0 && (pre_size == DEPTH || starve_m >= LIMIT || li < 0 || branch_haz)) begin
        s = cbuf_q.pop_front();
        r = '{wr: 1'b1, addr: s.addr, data: s.data, size: s.size, tag: 6'd0};
        exp_req_q.push_back(r);
        cur_pos_m = s.pos;
        cur_wr_m  = 1'b1;
        starve_m  = 0;
        phase_m   = 1;
      end else if (li >= 0 && !branch_haz) begin
        r = '{wr: 1'b0, addr: ld_addr_m[li], data: 32'd0, size: ld_size_m[li], tag: ld_tag_m[li]};
        exp_req_q.push_back(r);
        exp_ldr[li] = 1'b1;
        ld_pend[li] = 1'b0;
        if (pre_size > 0 && starve_m < LIMIT) starve_m++;
        cur_wr_m = 1'b0;
        phase_m  = 1;
      end
    end else if (phase_m == 1) begin
      if (dc_req_ready) phase_m = cur_wr_m ? 2 : 0;
    end else begin
      if (dc_wr_done) begin
        exp_done_q.push_back(cur_pos_m);
        phase_m = 0;
      end
    end
    chk("ld_req_ready", ld_req_ready, exp_ldr);
    if (pre_size <= DEPTH - N_WAY) begin
      for (int i = 0; i < N_WAY; i++) begin
        if (st_ret_valid[i]) begin
          s = '{addr: st_ret_addr[i*XLEN +: XLEN], data: st_ret_data[i*XLEN +: XLEN],
                size: st_ret_size[i*2 +: 2], pos: st_ret_pos[i*POS_W +: POS_W]};
          cbuf_q.push_back(s);
        end
      end
    end
  endtask

  // One clock: drive random inputs at the falling edge, then evaluate the model.
  task automatic cycle(input int p_ld, input int p_st, input int p_bh, input int p_rdy,
                       input int p_done, input bit rst);
    @(negedge clock);
    reset        = rst;
    st_ret_valid = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (!rst && !ld_pend[i] && ($urandom_range(99) < p_ld)) begin
        ld_pend[i]   = 1'b1;
        ld_addr_m[i] = $urandom;
        ld_size_m[i] = 2'($urandom_range(2));
        ld_tag_m[i]  = 6'($urandom);
      end
      ld_req_valid[i]                = ld_pend[i];
      ld_req_addr[i*XLEN +: XLEN]    = ld_addr_m[i];
      ld_req_size[i*2 +: 2]          = ld_size_m[i];
      ld_req_tag[i*TAG_W +: TAG_W]   = ld_tag_m[i];
      st_ret_addr[i*XLEN +: XLEN]    = $urandom;
      st_ret_data[i*XLEN +: XLEN]    = $urandom;
      st_ret_size[i*2 +: 2]          = 2'($urandom_range(2));
      st_ret_pos[i*POS_W +: POS_W]   = pos_ctr;
      if (!rst && cbuf_q.size() <= DEPTH - N_WAY && ($urandom_range(99) < p_st)) begin
        st_ret_valid[i] = 1'b1;
        pos_ctr = (pos_ctr == 4'd8) ? 4'd1 : pos_ctr + 4'd1;
      end
    end
    branch_haz   = ($urandom_range(99) < p_bh);
    dc_req_ready = ($urandom_range(99) < p_rdy);
    dc_wr_done   = ($urandom_range(99) < p_done);
    #1;
    model_eval();
  endtask

  initial begin
    int n;
    pos_ctr = 4'd1;
    phase_m = 0;
    starve_m = 0;
    for (int i = 0; i < N_WAY; i++) begin
      ld_pend[i] = 1'b0; ld_addr_m[i] = '0; ld_size_m[i] = '0; ld_tag_m[i] = '0;
    end
    reset = 1'b1; st_ret_valid = '0; ld_req_valid = '0; branch_haz = 1'b0;
    dc_req_ready = 1'b0; dc_wr_done = 1'b0;
    st_ret_addr = '0; st_ret_data = '0; st_ret_size = '0; st_ret_pos = '0;
    ld_req_addr = '0; ld_req_size = '0; ld_req_tag = '0;
    cycle(0, 0, 0, 0, 0, 1'b1);
    cycle(0, 0, 0, 0, 0, 1'b1);

    // Reset state
    cycle(0, 0, 0, 0, 0, 1'b0);
    chk("rst_done_valid", sq_done_valid, 1'b0);
    chk("rst_done_pos", sq_done_pos, 4'd0);
    chk("rst_req_addr", dc_req_addr, 32'd0);
    chk("rst_req_wr", dc_req_wr, 1'b0);

    // Traffic mixes: stores only, load pressure, dcache stalls, squashes, mixed
    for (int k = 0; k < 600; k++) cycle(0,   40, 0,   100, 30, 1'b0);
    for (int k = 0; k < 600; k++) cycle(100, 15, 0,   100, 50, 1'b0);
    for (int k = 0; k < 600; k++) cycle(60,  60, 10,  15,  40, 1'b0);
    for (int k = 0; k < 600; k++) cycle(80,  0,  100, 70,  50, 1'b0);
    for (int k = 0; k < 600; k++) cycle(50,  50, 25,  60,  30, 1'b0);

    // Reset while a store write waits for its completion
    n = 0;
    while (phase_m != 2 && n < 60) begin
      cycle(0, 100, 0, 100, 0, 1'b0);
      n++;
    end
    chk("reach_wait_ack", phase_m == 2, 1'b1);
    cycle(0, 0, 0, 100, 0, 1'b1);
    cycle(0, 0, 0, 100, 100, 1'b0);
    chk("post_rst_valid", dc_req_valid, 1'b0);
    chk("post_rst_count", cbuf_count, 3'd0);
    chk("post_rst_done", sq_done_valid, 1'b0);
    cycle(0, 0, 0, 100, 0, 1'b0);
    chk("late_done_ignored", sq_done_valid, 1'b0);

    // Drain everything still in flight
    for (int k = 0; k < 40; k++) cycle(0, 0, 0, 100, 100, 1'b0);
    chk("drain_req_q", exp_req_q.size(), 0);
    chk("drain_done_q", exp_done_q.size(), 0);
    chk("drain_cbuf", cbuf_count, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
